audio_fx_core: RTL

Parametrised next-generation audio effects engine for the recorder/player datapath. Sits between the codec sample interface and the playback path: captures a sample on each `sample_end` and presents one output sample on each `sample_req`. Supports silence, sine-tone generation with programmable step, gain-scaled feedback with saturation, and an optional echo mode built on a circular delay buffer.

---
 rtl/audio_fx_pkg.sv | 32 +++
 rtl/audio_fx_sine_rom.sv | 38 +++
 rtl/audio_fx_core.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effects engine: mode bit positions and a
// signed saturation helper used by the gain and echo paths.
package audio_fx_pkg;

  // Bit positions within the 4-bit control word (bit 3 is reserved).
  localparam int unsigned MODE_SINE     = 0;
  localparam int unsigned MODE_FEEDBACK = 1;
  localparam int unsigned MODE_ECHO     = 2;

  // Clamp a sign-extended in_w-bit value into the signed out_w-bit range.
  // Callers sign-extend to 64 bits and truncate the result to out_w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                  input int unsigned        in_w,
                                                  input int unsigned        out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res = val;
    // A value that already fits the output width cannot overflow.
    if (in_w > out_w) begin
      if (val > hi) begin
        res = hi;
      end else if (val < lo) begin
        res = lo;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_fx_sine_rom.sv
// One-period sine lookup table. Entries are computed at elaboration as
// round((2^(DATA_W-1)-1) * sin(2*pi*k/TABLE_DEPTH)); read is combinational.
module audio_fx_sine_rom #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TABLE_DEPTH = 100
) (
  input  logic [$clog2(TABLE_DEPTH)-1:0] addr,
  output logic [DATA_W-1:0]              data
);

  function automatic logic [DATA_W-1:0] sine_entry(input int k);
    real amp;
    real x;
    amp = real'((64'd1 << (DATA_W - 1)) - 64'd1);
    x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(TABLE_DEPTH));
    // Round half away from zero.
    if (x >= 0.0) begin
      return DATA_W'($rtoi(x + 0.5));
    end
    return DATA_W'($rtoi(x - 0.5));
  endfunction

  logic [DATA_W-1:0] rom [TABLE_DEPTH];

  for (genvar k = 0; k < TABLE_DEPTH; k++) begin : g_rom
    localparam logic [DATA_W-1:0] Entry = sine_entry(k);
    assign rom[k] = Entry;
  end

  // Table read; addresses past the last entry return 0.
  always_comb begin
    data = '0;
    if (32'(addr) < TABLE_DEPTH) begin
      data = rom[addr];
    end
  end

endmodule

// File: rtl/audio_fx_core.sv
// Audio effects engine: silence, sine tone, gain-scaled feedback and an
// optional echo over a circular delay buffer. Define AUDIO_FX_ECHO_EN to
// build the delay buffer and ECHO mode; otherwise control[2] is ignored.
module audio_fx_core
  import audio_fx_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned VOL_W       = 2,
  parameter int unsigned TABLE_DEPTH = 100,
  parameter int unsigned STEP_W      = 7,
  parameter int unsigned DELAY_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_end,
  input  logic              sample_req,
  input  logic [DATA_W-1:0] audio_input,
  output logic [DATA_W-1:0] audio_output,
  input  logic [VOL_W-1:0]  volume_control,
  input  logic [STEP_W-1:0] freq_step,
  input  logic [3:0]        control
);

  localparam int unsigned IdxW  = $clog2(TABLE_DEPTH);
  localparam int unsigned ProdW = DATA_W + VOL_W + 1;
  localparam logic [STEP_W-1:0] MaxStep = STEP_W'(TABLE_DEPTH - 1);

  logic [DATA_W-1:0] last_sample_q, last_sample_d;
  logic [IdxW-1:0]   index_q, index_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic [DATA_W-1:0]       sine_val;
  logic signed [ProdW-1:0] prod;
  logic [DATA_W-1:0]       fb_sat;
  logic [STEP_W-1:0]       step_clamped;
  logic [IdxW:0]           idx_sum;
  logic [IdxW-1:0]         idx_next;
  logic                    echo_sel;
  logic [DATA_W-1:0]       echo_sat;
  logic                    unused_ctrl;

  assign unused_ctrl  = control[3];
  assign audio_output = out_q;

  audio_fx_sine_rom #(
    .DATA_W      (DATA_W),
    .TABLE_DEPTH (TABLE_DEPTH)
  ) u_sine_rom (
    .addr (index_q),
    .data (sine_val)
  );

  // Signed sample times unsigned volume, then saturate to the sample range.
  always_comb begin
    prod   = $signed({{(VOL_W + 1){last_sample_q[DATA_W-1]}}, last_sample_q}) *
             $signed({{(DATA_W + 1){1'b0}}, volume_control});
    fb_sat = DATA_W'(saturate(64'(prod), ProdW, DATA_W));
  end

  // Next sine index: clamp the step, add, and wrap once modulo the table depth.
  always_comb begin
    step_clamped = (freq_step > MaxStep) ? MaxStep : freq_step;
    idx_sum      = {1'b0, index_q} + (IdxW + 1)'(step_clamped);
    idx_next     = IdxW'(idx_sum);
    if (idx_sum >= (IdxW + 1)'(TABLE_DEPTH)) begin
      idx_next = IdxW'(idx_sum - (IdxW + 1)'(TABLE_DEPTH));
    end
  end

`ifdef AUDIO_FX_ECHO_EN
  localparam int unsigned PtrW = $clog2(DELAY_DEPTH);
  localparam logic [PtrW:0] FillFull = (PtrW + 1)'(DELAY_DEPTH);

  logic [DATA_W-1:0]      dly_mem [DELAY_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]          fill_q, fill_d;
  logic signed [DATA_W-1:0] dly_term;
  logic signed [DATA_W:0]   echo_sum;

  assign echo_sel = control[MODE_ECHO];

  // Echo mix: the entry at wr_ptr is the oldest one, masked until the buffer has filled.
  always_comb begin
    dly_term = '0;
    if (fill_q == FillFull) begin
      dly_term = $signed(dly_mem[wr_ptr_q]) >>> 1;
    end
    echo_sum = $signed({fb_sat[DATA_W-1], fb_sat}) + $signed({dly_term[DATA_W-1], dly_term});
    echo_sat = DATA_W'(saturate(64'(echo_sum), DATA_W + 1, DATA_W));
  end

  // Write pointer wraps naturally; fill counter saturates at the buffer depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (sample_end) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (fill_q != FillFull) begin
        fill_d = fill_q + (PtrW + 1)'(1);
      end
    end
  end

  // Delay RAM: written on every captured sample regardless of mode; never cleared.
  always_ff @(posedge clk) begin
    if (!reset && sample_end) begin
      dly_mem[wr_ptr_q] <= audio_input;
    end
  end

  // Echo pointer and fill state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end
`else
  logic unused_cfg;

  assign echo_sel   = 1'b0;
  assign echo_sat   = '0;
  assign unused_cfg = ^{control[MODE_ECHO], 32'(DELAY_DEPTH)};
`endif

  // Capture and output selection; priority ECHO > FEEDBACK > SINE > silence.
  always_comb begin
    last_sample_d = last_sample_q;
    index_d       = index_q;
    out_d         = out_q;
    if (sample_end) begin
      last_sample_d = audio_input;
    end
    if (sample_req) begin
      if (echo_sel) begin
        out_d = echo_sat;
      end else if (control[MODE_FEEDBACK]) begin
        out_d = fb_sat;
      end else if (control[MODE_SINE]) begin
        out_d   = sine_val;
        index_d = idx_next;
      end else begin
        out_d = '0;
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sample_q <= '0;
      index_q       <= '0;
      out_q         <= '0;
    end else begin
      last_sample_q <= last_sample_d;
      index_q       <= index_d;
      out_q         <= out_d;
    end
  end

endmodule
